// File: rtl/ball_pkg.sv
// Shared types and constants for the ball plotting controller and its pixel counter.
package ball_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LD_OLD,
        ERASE,
        LD_NEW,
        DRAW,
        DONE
    } state_t;

    localparam int PIX_COUNT = 16;
    localparam int COUNTER_W = 4;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/ball_control_pixel_counter.sv
// Pixel index counter for the 4x4 ball; shared between the erase and draw bursts.
module pixel_counter
    import ball_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 enable,
    output logic [COUNTER_W-1:0] count,
    output logic                 last
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == COUNTER_W'(PIX_COUNT - 1));

endmodule

// File: rtl/ball_control.sv
// Sequences one ball move: optional erase at the old position, then draw at the new one.
// Define BALL_CONTROL_ERASE_EN to enable the erase pass; otherwise every move only draws.
module ball_control
    import ball_pkg::*;
#(
    parameter int         X_W       = 8,
    parameter int         Y_W       = 7,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           go,
    input  logic [X_W-1:0] x_new,
    input  logic [Y_W-1:0] y_new,
    input  logic [2:0]     ball_colour,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           ld_x,
    output logic           ld_y,
    output logic [3:0]     counter,
    output logic           plot,
    output logic [2:0]     colour,
    output logic           busy,
    output logic           done
);

    state_t         state;
    logic [X_W-1:0] new_x;
    logic [Y_W-1:0] new_y;
    logic [2:0]     new_colour;
    logic           pix_last;
    logic           plotting;

`ifdef BALL_CONTROL_ERASE_EN
    logic [X_W-1:0] old_x;
    logic [Y_W-1:0] old_y;
    logic           old_valid;
`endif

    assign plotting = (state == ERASE) || (state == DRAW);

    // The counter sits at zero outside plot bursts so each burst starts at pixel 0.
    pixel_counter u_pixel_counter (
        .clock  (clock),
        .clear  (reset || !plotting),
        .enable (plotting),
        .count  (counter),
        .last   (pix_last)
    );

    // Outputs are registered alongside the state so they line up with the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            x_out      <= '0;
            y_out      <= '0;
            ld_x       <= 1'b1;
            ld_y       <= 1'b1;
            plot       <= 1'b0;
            colour     <= BLACK;
            busy       <= 1'b0;
            done       <= 1'b0;
            new_x      <= '0;
            new_y      <= '0;
            new_colour <= BLACK;
`ifdef BALL_CONTROL_ERASE_EN
            old_x      <= '0;
            old_y      <= '0;
            old_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        new_x      <= x_new;
                        new_y      <= y_new;
                        new_colour <= ball_colour;
                        ld_x       <= 1'b0;
                        ld_y       <= 1'b0;
                        busy       <= 1'b1;
`ifdef BALL_CONTROL_ERASE_EN
                        if (old_valid) begin
                            state <= LD_OLD;
                            x_out <= old_x;
                            y_out <= old_y;
                        end else begin
                            state <= LD_NEW;
                            x_out <= x_new;
                            y_out <= y_new;
                        end
`else
                        state <= LD_NEW;
                        x_out <= x_new;
                        y_out <= y_new;
`endif
                    end
                end
`ifdef BALL_CONTROL_ERASE_EN
                LD_OLD: begin
                    state  <= ERASE;
                    ld_x   <= 1'b1;
                    ld_y   <= 1'b1;
                    plot   <= 1'b1;
                    colour <= BG_COLOUR;
                end
                ERASE: begin
                    if (pix_last) begin
                        state  <= LD_NEW;
                        x_out  <= new_x;
                        y_out  <= new_y;
                        ld_x   <= 1'b0;
                        ld_y   <= 1'b0;
                        plot   <= 1'b0;
                        colour <= BG_COLOUR;
                    end
                end
`endif
                LD_NEW: begin
                    state  <= DRAW;
                    ld_x   <= 1'b1;
                    ld_y   <= 1'b1;
                    plot   <= 1'b1;
                    colour <= new_colour;
                end
                DRAW: begin
                    if (pix_last) begin
                        state  <= DONE;
                        plot   <= 1'b0;
                        colour <= BG_COLOUR;
                        done   <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
`ifdef BALL_CONTROL_ERASE_EN
                    old_x     <= new_x;
                    old_y     <= new_y;
                    old_valid <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                    ld_x  <= 1'b1;
                    ld_y  <= 1'b1;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
